// File: rtl/lvda_timing_pkg.sv
// Shared LVDA timing definitions: phase-state encoding, default timing and phase indices.
// Used by lvda_phase_gen and by any phase-timing checker that decodes the W/X/Y/Z drives.
package lvda_timing_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_PW   = 4'd1,
        ST_GW   = 4'd2,
        ST_PX   = 4'd3,
        ST_GX   = 4'd4,
        ST_PY   = 4'd5,
        ST_GY   = 4'd6,
        ST_PZ   = 4'd7,
        ST_GZ   = 4'd8
    } phase_state_e;

    localparam int unsigned DEF_PHASE_LEN     = 2;
    localparam int unsigned DEF_GAP_LEN       = 1;
    localparam int unsigned DEF_BITS_PER_WORD = 39;

    localparam int unsigned PH_W = 0;
    localparam int unsigned PH_X = 1;
    localparam int unsigned PH_Y = 2;
    localparam int unsigned PH_Z = 3;

    // Dwell counter counts 0..max(len)-1; never narrower than one bit.
    function automatic int unsigned dwell_width(input int unsigned phase_len,
                                                input int unsigned gap_len);
        int unsigned m;
        m = (phase_len > gap_len) ? phase_len : gap_len;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic logic [3:0] phase_drive(input phase_state_e st);
        logic [3:0] d;
        d = '0;
        case (st)
            ST_PW:   d[PH_W] = 1'b1;
            ST_PX:   d[PH_X] = 1'b1;
            ST_PY:   d[PH_Y] = 1'b1;
            ST_PZ:   d[PH_Z] = 1'b1;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lvda_bit_counter.sv
// Modulo-MOD bit-time counter: advances on inc_i, wraps MOD-1 -> 0, flags the terminal count.
module lvda_bit_counter
#(
    parameter int unsigned MOD = 39,
    parameter int unsigned W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign term_o = (cnt_q == W'(MOD - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = term_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lvda_phase_gen.sv
// LVDA four-phase (W/X/Y/Z) non-overlapping drive generator with bit-time and word-end tracking.
// Define LVDA_PHASE_STEP_EN to enable STEP_MODE/STEP single-bit stepping; otherwise RUN only.
module lvda_phase_gen
    import lvda_timing_pkg::*;
#(
    parameter int unsigned PHASE_LEN     = DEF_PHASE_LEN,
    parameter int unsigned GAP_LEN       = DEF_GAP_LEN,
    parameter int unsigned BITS_PER_WORD = DEF_BITS_PER_WORD,
    parameter int unsigned BIT_W         = 6
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST,
    input  logic             RUN,
    input  logic             STEP_MODE,
    input  logic             STEP,
    output logic             WDA,
    output logic             XDA,
    output logic             YDA,
    output logic             ZDA,
    output logic [BIT_W-1:0] BIT_CNT,
    output logic             WORD_END,
    output logic             BUSY
);

    localparam int unsigned     DW       = dwell_width(PHASE_LEN, GAP_LEN);
    localparam logic [DW-1:0]   PH_LAST  = DW'(PHASE_LEN - 1);
    localparam logic [DW-1:0]   GAP_LAST = DW'(GAP_LEN - 1);

    phase_state_e     state_q;
    logic [DW-1:0]    dwell_q;
    logic [3:0]       drive_q;
    logic             busy_q;
    logic             word_end_q;
    logic [BIT_W-1:0] bit_cnt_q;

    logic             in_phase;
    logic             dwell_done;
    logic             gz_exit;
    logic             bit_term;
    logic [BIT_W-1:0] bit_cnt;
    logic             launch;
    logic             resume;

    assign in_phase   = (state_q == ST_PW) || (state_q == ST_PX) ||
                        (state_q == ST_PY) || (state_q == ST_PZ);
    assign dwell_done = (dwell_q == (in_phase ? PH_LAST : GAP_LAST));
    assign gz_exit    = (state_q == ST_GZ) && dwell_done;

`ifdef LVDA_PHASE_STEP_EN
    logic step_q;
    logic step_rise;

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            step_q <= 1'b0;
        end else begin
            step_q <= STEP;
        end
    end

    // Edges seen while busy are simply lost: only IDLE consults step_rise.
    assign step_rise = STEP & ~step_q;
    assign launch    = STEP_MODE ? step_rise : RUN;
    assign resume    = ~STEP_MODE & RUN;
`else
    logic unused_step;
    assign unused_step = STEP_MODE ^ STEP;
    assign launch      = RUN;
    assign resume      = RUN;
`endif

    lvda_bit_counter #(
        .MOD (BITS_PER_WORD),
        .W   (BIT_W)
    ) u_bit_counter (
        .clk    (SIM_CLK),
        .rst_n  (SIM_RST),
        .inc_i  (gz_exit),
        .cnt_o  (bit_cnt),
        .term_o (bit_term)
    );

    // Outputs are decoded from the current state and registered, so every pin lags the FSM by one cycle.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state_q    <= ST_IDLE;
            dwell_q    <= '0;
            drive_q    <= '0;
            busy_q     <= 1'b0;
            word_end_q <= 1'b0;
            bit_cnt_q  <= '0;
        end else begin
            drive_q    <= phase_drive(state_q);
            busy_q     <= (state_q != ST_IDLE);
            word_end_q <= gz_exit & bit_term;
            bit_cnt_q  <= bit_cnt;

            if (state_q == ST_IDLE) begin
                dwell_q <= '0;
                if (launch) begin
                    state_q <= ST_PW;
                end
            end else if (dwell_done) begin
                dwell_q <= '0;
                case (state_q)
                    ST_PW:   state_q <= ST_GW;
                    ST_GW:   state_q <= ST_PX;
                    ST_PX:   state_q <= ST_GX;
                    ST_GX:   state_q <= ST_PY;
                    ST_PY:   state_q <= ST_GY;
                    ST_GY:   state_q <= ST_PZ;
                    ST_PZ:   state_q <= ST_GZ;
                    ST_GZ:   state_q <= resume ? ST_PW : ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end else begin
                dwell_q <= dwell_q + DW'(1);
            end
        end
    end

    assign WDA      = drive_q[PH_W];
    assign XDA      = drive_q[PH_X];
    assign YDA      = drive_q[PH_Y];
    assign ZDA      = drive_q[PH_Z];
    assign BUSY     = busy_q;
    assign WORD_END = word_end_q;
    assign BIT_CNT  = bit_cnt_q;

endmodule

// File: tb/tb_lvda_phase_gen.sv
// Scoreboard bench for lvda_phase_gen: default-timing instance plus a PHASE_LEN=1/GAP_LEN=3/2-bit-word instance.
module tb_lvda_phase_gen;

    typedef struct packed {
        logic       w;
        logic       x;
        logic       y;
        logic       z;
        logic       busy;
        logic       we;
        logic [5:0] cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       run = 1'b0;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;

    logic       wda1, xda1, yda1, zda1, we1, busy1;
    logic [5:0] cnt1;
    logic       wda2, xda2, yda2, zda2, we2, busy2;
    logic [5:0] cnt2;

    obs_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string tag = "init";

    always #5 clk = ~clk;

    lvda_phase_gen dut (
        .SIM_CLK (clk), .SIM_RST (rst_n), .RUN (run),
        .STEP_MODE (step_mode), .STEP (step),
        .WDA (wda1), .XDA (xda1), .YDA (yda1), .ZDA (zda1),
        .BIT_CNT (cnt1), .WORD_END (we1), .BUSY (busy1)
    );

    lvda_phase_gen #(
        .PHASE_LEN (1), .GAP_LEN (3), .BITS_PER_WORD (2), .BIT_W (6)
    ) dut2 (
        .SIM_CLK (clk), .SIM_RST (rst_n), .RUN (run),
        .STEP_MODE (step_mode), .STEP (step),
        .WDA (wda2), .XDA (xda2), .YDA (yda2), .ZDA (zda2),
        .BIT_CNT (cnt2), .WORD_END (we2), .BUSY (busy2)
    );

    function automatic obs_t mk(input logic [3:0] ph, input logic busy, input logic we, input int cnt);
        obs_t o;
        o.w = ph[0]; o.x = ph[1]; o.y = ph[2]; o.z = ph[3];
        o.busy = busy; o.we = we; o.cnt = 6'(cnt);
        return o;
    endfunction

    function automatic obs_t sample(input bit sel);
        obs_t o;
        if (sel) begin
            o.w = wda2; o.x = xda2; o.y = yda2; o.z = zda2;
            o.busy = busy2; o.we = we2; o.cnt = cnt2;
        end else begin
            o.w = wda1; o.x = xda1; o.y = yda1; o.z = zda1;
            o.busy = busy1; o.we = we1; o.cnt = cnt1;
        end
        return o;
    endfunction

    task automatic push_idle(input int cnt, input int n);
        repeat (n) exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, cnt));
    endtask

    // One bit time as seen on the pins: PL cycles of each phase, then GL cycles all low.
    task automatic push_bits(input int first, input int n, input int bpw, input int pl, input int gl);
        for (int b = 0; b < n; b++) begin
            int c;
            c = (first + b) % bpw;
            for (int p = 0; p < 4; p++) begin
                for (int i = 0; i < pl; i++) exp_q.push_back(mk(4'(1 << p), 1'b1, 1'b0, c));
                for (int i = 0; i < gl; i++)
                    exp_q.push_back(mk(4'b0000, 1'b1, (c == bpw - 1) && (p == 3) && (i == gl - 1), c));
            end
        end
    endtask

    task automatic drain(input int n, input bit sel);
        for (int k = 0; k < n && exp_q.size() > 0; k++) begin
            obs_t o;
            obs_t e;
            @(negedge clk);
            o = sample(sel);
            e = exp_q.pop_front();
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h (w x y z busy we cnt)", tag, o, e);
            end
            checks++;
            assert ($countones({o.w, o.x, o.y, o.z}) <= 1) else begin
                errors++;
                $error("FAIL %s_onehot: observed phases %b expected at most one high", tag, {o.w, o.x, o.y, o.z});
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tag = "reset";
        checks++;
        assert (sample(0) === mk(4'b0000, 1'b0, 1'b0, 0)) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, sample(0), mk(4'b0000, 1'b0, 1'b0, 0));
        end
        rst_n = 1'b1;
        tag = "idle_run0";
        push_idle(0, 2);
        drain(2, 0);

        // RUN high before edge 0: idle sample, then W on edges 1-2, X 4-5, Y 7-8, Z 10-11, W again at 13.
        run = 1'b1;
        push_idle(0, 1);
        push_bits(0, 45, 39, 2, 1);
        tag = "first_bit";
        drain(14, 0);
        tag = "word";
        drain(1 + 44 * 12 + 4 - 14, 0);

        // Now in PX of bit 5 of the second word: the bit must still finish.
        run = 1'b0;
        push_idle(6, 3);
        tag = "stop";
        drain(exp_q.size(), 0);

        run = 1'b1;
        push_idle(6, 1);
        push_bits(6, 2, 39, 2, 1);
        tag = "resume";
        drain(1 + 12 + 7, 0);

        // Last sample showed YDA: drop reset between edges.
        tag = "async_rst";
        #2 rst_n = 1'b0;
        #1;
        checks++;
        assert (sample(0) === mk(4'b0000, 1'b0, 1'b0, 0)) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, sample(0), mk(4'b0000, 1'b0, 1'b0, 0));
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(0, 1);
        push_bits(0, 1, 39, 2, 1);
        tag = "post_rst";
        drain(6, 0);
        run = 1'b0;
        push_idle(1, 2);
        drain(exp_q.size(), 0);

        step_mode = 1'b1;
`ifdef LVDA_PHASE_STEP_EN
        tag = "step";
        step = 1'b1;
        push_idle(1, 1);
        push_bits(1, 1, 39, 2, 1);
        push_idle(2, 3);
        drain(3, 0);
        step = 1'b0;
        drain(2, 0);
        step = 1'b1;
        drain(3, 0);
        step = 1'b0;
        drain(exp_q.size(), 0);
`else
        tag = "step_ignored";
        push_idle(1, 8);
        for (int i = 0; i < 2; i++) begin
            step = 1'b1;
            drain(2, 0);
            step = 1'b0;
            drain(2, 0);
        end
`endif
        step_mode = 1'b0;

        // Short-bit instance: 16-cycle bits, BIT_CNT 0/1, WORD_END every 32 cycles.
        @(negedge clk);
        rst_n = 1'b0;
        run = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(0, 1);
        push_bits(0, 4, 2, 1, 3);
        tag = "short_bits";
        drain(1 + 63, 1);
        run = 1'b0;
        push_idle(0, 2);
        drain(exp_q.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
